// File: rtl/hwpe_stream_sink_2d.sv
// hwpe_stream_sink_2d
//   Multi-port HWPE stream sink. Each NB_TCDM_PORTS*32-bit input beat is split
//   into one 32-bit TCDM write per port. Every port is granted independently.
//   A beat is accepted once every port that has work for it has been granted.
//   Addressing is word-aligned 2D (line length + line stride).
// Ports
//   clk_i, rst_i, clear_i         clock, synchronous active-high reset / soft clear
//   start_i + config inputs       base_addr_i, trans_size_i, line_length_i, line_stride_i
//   stream_*                      input stream (data, strb, valid, ready)
//   tcdm_*                        per-port TCDM write request channel
//   busy_o, done_o                status (busy in WORKING/DONE, done one-cycle pulse)

// Per-port write lane: tracks whether this port's slice of the current beat
// has already been granted, so it is written exactly once.
module hwpe_stream_sink_2d_port (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        working,
    input  logic        valid,
    input  logic        accept,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  strb,
    input  logic        gnt,
    output logic        req,
    output logic        ok,
    output logic [31:0] tcdm_add,
    output logic [31:0] tcdm_data,
    output logic [3:0]  tcdm_be
);
    logic served_q;
    logic active;

    assign active = |strb;
    assign req    = working & valid & active & ~served_q;
    // This port no longer blocks acceptance: idle slice, already written, or granted now.
    assign ok     = ~active | served_q | gnt;

    assign tcdm_add  = working ? addr : '0;
    assign tcdm_data = working ? data : '0;
    assign tcdm_be   = working ? strb : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            served_q <= 1'b0;
        else if (accept)
            served_q <= 1'b0;
        else if (req & gnt)
            served_q <= 1'b1;
    end
endmodule

module hwpe_stream_sink_2d #(
    parameter int unsigned NB_TCDM_PORTS = 4,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [31:0]                  base_addr_i,
    input  logic [CNT_WIDTH-1:0]         trans_size_i,
    input  logic [CNT_WIDTH-1:0]         line_length_i,
    input  logic [31:0]                  line_stride_i,
    input  logic [NB_TCDM_PORTS*32-1:0]  stream_data_i,
    input  logic [NB_TCDM_PORTS*4-1:0]   stream_strb_i,
    input  logic                         stream_valid_i,
    output logic                         stream_ready_o,
    output logic [NB_TCDM_PORTS-1:0]     tcdm_req_o,
    input  logic [NB_TCDM_PORTS-1:0]     tcdm_gnt_i,
    output logic [NB_TCDM_PORTS*32-1:0]  tcdm_add_o,
    output logic [NB_TCDM_PORTS-1:0]     tcdm_wen_o,
    output logic [NB_TCDM_PORTS*4-1:0]   tcdm_be_o,
    output logic [NB_TCDM_PORTS*32-1:0]  tcdm_data_o,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int unsigned NB = NB_TCDM_PORTS;

    typedef enum logic [1:0] {IDLE, WORKING, DONE} state_t;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] trans_size_q;
    logic [CNT_WIDTH-1:0] line_length_q;
    logic [CNT_WIDTH-1:0] beat_cnt_q;
    logic [CNT_WIDTH-1:0] col_q;
    logic [31:0]          line_stride_q;
    logic [31:0]          line_base_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 soft_rst;
    logic                 working;
    logic                 accept;
    logic                 last_beat;
    logic                 line_end;
    logic [31:0]          beat_base;
    logic [NB-1:0]        port_ok;

    assign soft_rst = rst_i | clear_i;
    // Reset/clear gate the handshake outputs combinationally, not just at the next edge.
    assign working  = (state_q == WORKING) & ~soft_rst;
    assign accept   = working & stream_valid_i & (&port_ok);

    assign last_beat = (beat_cnt_q == trans_size_q - CNT_WIDTH'(1));
    assign line_end  = (line_length_q != '0) && (col_q == line_length_q - CNT_WIDTH'(1));
    assign beat_base = line_base_q + 32'(col_q) * 32'(NB * 4);

    assign stream_ready_o = accept;
    assign tcdm_wen_o     = '0;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

    for (genvar p = 0; p < NB; p++) begin : g_port
        hwpe_stream_sink_2d_port i_port (
            .clk_i     (clk_i),
            .rst_i     (soft_rst),
            .working   (working),
            .valid     (stream_valid_i),
            .accept    (accept),
            .addr      (beat_base + 32'(4 * p)),
            .data      (stream_data_i[32*p +: 32]),
            .strb      (stream_strb_i[4*p +: 4]),
            .gnt       (tcdm_gnt_i[p]),
            .req       (tcdm_req_o[p]),
            .ok        (port_ok[p]),
            .tcdm_add  (tcdm_add_o[32*p +: 32]),
            .tcdm_data (tcdm_data_o[32*p +: 32]),
            .tcdm_be   (tcdm_be_o[4*p +: 4])
        );
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q       <= IDLE;
            trans_size_q  <= '0;
            line_length_q <= '0;
            line_stride_q <= '0;
            line_base_q   <= '0;
            col_q         <= '0;
            beat_cnt_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        trans_size_q  <= trans_size_i;
                        line_length_q <= line_length_i;
                        line_stride_q <= line_stride_i;
                        line_base_q   <= {base_addr_i[31:2], 2'b00};
                        col_q         <= '0;
                        beat_cnt_q    <= '0;
                        busy_q        <= 1'b1;
                        if (trans_size_i != '0) begin
                            state_q <= WORKING;
                        end else begin
                            // Empty transfer: report completion without touching TCDM.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                WORKING: begin
                    if (accept) begin
                        if (last_beat) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
                        end
                        if (line_end) begin
                            col_q       <= '0;
                            line_base_q <= line_base_q + line_stride_q;
                        end else begin
                            col_q <= col_q + CNT_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hwpe_stream_sink_2d.sv
// Testbench for hwpe_stream_sink_2d: driver issues transfers and pushes the
// expected per-port writes into queues; a negedge monitor pops and compares.
module tb_hwpe_stream_sink_2d;
    localparam int NB = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i, clear_i, start_i;
    logic [31:0]          base_addr_i, line_stride_i;
    logic [CW-1:0]        trans_size_i, line_length_i;
    logic [NB*32-1:0]     stream_data_i;
    logic [NB*4-1:0]      stream_strb_i;
    logic                 stream_valid_i, stream_ready_o;
    logic [NB-1:0]        tcdm_req_o, tcdm_gnt_i, tcdm_wen_o;
    logic [NB*32-1:0]     tcdm_add_o, tcdm_data_o;
    logic [NB*4-1:0]      tcdm_be_o;
    logic                 busy_o, done_o;

    hwpe_stream_sink_2d #(.NB_TCDM_PORTS(NB), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .trans_size_i(trans_size_i),
        .line_length_i(line_length_i), .line_stride_i(line_stride_i),
        .stream_data_i(stream_data_i), .stream_strb_i(stream_strb_i),
        .stream_valid_i(stream_valid_i), .stream_ready_o(stream_ready_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t           exp_q[NB][$];
    logic [NB-1:0] beat_act[256];
    int total = 0, bad = 0;
    int acc_cnt, exp_trans, done_seen = 0, first_acc, last_acc, cyc = 0;
    int wr_cnt[NB], req_cyc[NB];
    bit gnt_mode = 1'b0;
    logic [NB-1:0] hold_mask = '0;
    int hold_left = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Grant generator: random or all-ones, with an optional per-port hold that
    // counts down only while the block is busy.
    initial begin
        logic [NB-1:0] g;
        tcdm_gnt_i = '0;
        forever begin
            @(posedge clk);
            #2;
            g = gnt_mode ? {NB{1'b1}} : NB'($urandom);
            if (hold_left > 0) begin
                g = g & ~hold_mask;
                if (busy_o) hold_left--;
            end
            tcdm_gnt_i = g;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        wr_t e;
        int n;
        if (!rst_i && !clear_i) begin
            for (int p = 0; p < NB; p++) begin
                if (tcdm_req_o[p]) req_cyc[p]++;
                if (tcdm_req_o[p] && tcdm_gnt_i[p]) begin
                    if (exp_q[p].size() == 0) begin
                        total++; bad++;
                        $display("FAIL spurious_write: port %0d addr %0h with no write expected",
                                 p, tcdm_add_o[32*p +: 32]);
                    end else begin
                        e = exp_q[p].pop_front();
                        chk($sformatf("write_p%0d", p),
                            {tcdm_wen_o[p], tcdm_add_o[32*p +: 32], tcdm_data_o[32*p +: 32], tcdm_be_o[4*p +: 4]},
                            {1'b0, e.addr, e.data, e.be});
                    end
                    wr_cnt[p]++;
                end
            end
            if (stream_ready_o) begin
                for (int p = 0; p < NB; p++) begin
                    n = 0;
                    for (int b = 0; b <= acc_cnt && b < 256; b++) n += int'(beat_act[b][p]);
                    chk($sformatf("ready_writes_p%0d", p), 128'(wr_cnt[p]), 128'(n));
                end
                if (acc_cnt == 0) first_acc = cyc;
                last_acc = cyc;
                acc_cnt++;
            end
            if (done_o) begin
                chk("done_count", 128'(acc_cnt), 128'(exp_trans));
                if (exp_trans > 0) chk("done_timing", 128'(cyc), 128'(last_acc + 1));
                chk("done_busy", 128'(busy_o), 128'(1));
                done_seen++;
            end
        end
    end

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // One cycle forward; after the start cycle config inputs wander and start
    // may pulse (it must be ignored while the block is busy).
    task automatic step(input bit allow_start);
        @(posedge clk);
        #1;
        start_i       = allow_start ? 1'($urandom_range(1, 0)) : 1'b0;
        base_addr_i   = $urandom;
        trans_size_i  = CW'($urandom);
        line_length_i = CW'($urandom_range(3, 0));
        line_stride_i = $urandom;
    endtask

    task automatic run_xfer(input logic [31:0] base, input int trans, input int len,
                            input logic [31:0] stride, input int smode, input int maxgap,
                            input int abort_at, input bit use_clear);
        int d0, tmo, g, li, co, left;
        bit acc;
        logic [NB*32-1:0] data;
        logic [NB*4-1:0]  strb;
        logic [31:0]      a;
        for (int p = 0; p < NB; p++) begin
            exp_q[p].delete();
            wr_cnt[p]  = 0;
            req_cyc[p] = 0;
        end
        acc_cnt   = 0;
        exp_trans = trans;
        d0        = done_seen;
        start_i       = 1'b1;
        base_addr_i   = base;
        trans_size_i  = CW'(trans);
        line_length_i = CW'(len);
        line_stride_i = stride;
        if (trans == 0) step(1'b0);
        for (int b = 0; b < trans; b++) begin
            if (b > 0 && maxgap > 0) begin
                g = $urandom_range(maxgap, 0);
                if (g > 0) begin
                    stream_valid_i = 1'b0;
                    repeat (g) step(b < trans - 1);
                end
            end
            for (int p = 0; p < NB; p++) data[32*p +: 32] = $urandom;
            case (smode)
                1: strb = '1;
                2: strb = (b == 0) ? 16'hFF0F : (b == 1) ? 16'h0000 : 16'hFFFF;
                default: begin
                    strb = NB*4'($urandom);
                    for (int p = 0; p < NB; p++)
                        if ($urandom_range(3, 0) == 0) strb[4*p +: 4] = 4'h0;
                    if ($urandom_range(7, 0) == 0) strb = '0;
                end
            endcase
            li = (len != 0) ? b / len : 0;
            co = (len != 0) ? b % len : b;
            for (int p = 0; p < NB; p++) begin
                beat_act[b][p] = |strb[4*p +: 4];
                a = (base & 32'hFFFF_FFFC) + 32'(li) * stride + 32'(co * NB * 4 + 4 * p);
                if (beat_act[b][p]) exp_q[p].push_back('{a, data[32*p +: 32], strb[4*p +: 4]});
            end
            if (b == abort_at) begin
                hold_mask = 4'b0001;
                hold_left = 1000;
            end
            stream_data_i  = data;
            stream_strb_i  = strb;
            stream_valid_i = 1'b1;
            if (b == abort_at) begin
                @(negedge clk);
                @(posedge clk);
                #1;
                if (use_clear) clear_i = 1'b1; else rst_i = 1'b1;
                start_i = 1'b0;
                @(negedge clk);
                chk("abort_forced_handshake", {tcdm_req_o, stream_ready_o}, '0);
                @(posedge clk);
                #1;
                rst_i = 1'b0; clear_i = 1'b0; stream_valid_i = 1'b0; hold_left = 0;
                @(negedge clk);
                chk("abort_ctrl_zero", {tcdm_req_o, stream_ready_o, busy_o, done_o}, '0);
                chk("abort_add_zero", tcdm_add_o, '0);
                chk("abort_data_be_zero", {tcdm_data_o[111:0], tcdm_be_o}, '0);
                for (int p = 0; p < NB; p++) exp_q[p].delete();
                @(posedge clk);
                #1;
                return;
            end
            tmo = 0;
            do begin
                @(negedge clk);
                acc = stream_ready_o;
                step(b < trans - 1);
                tmo++;
                if (tmo > 300) begin
                    total++; bad++;
                    $display("FAIL accept_timeout: beat %0d never accepted, wanted within 300 cycles", b);
                    finish_now();
                end
            end while (!acc);
        end
        stream_valid_i = 1'b0;
        tmo = 0;
        while (done_seen == d0) begin
            @(posedge clk);
            #1;
            tmo++;
            if (tmo > 50) begin
                total++; bad++;
                $display("FAIL done_timeout: no done pulse, wanted within 50 cycles");
                finish_now();
            end
        end
        left = 0;
        for (int p = 0; p < NB; p++) left += exp_q[p].size();
        chk("writes_outstanding", 128'(left), 128'(0));
    endtask

    initial begin
        int d0;
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b1;
        base_addr_i = 32'h1000; trans_size_i = 16'd4; line_length_i = '0; line_stride_i = '0;
        stream_data_i = '1; stream_strb_i = '1; stream_valid_i = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ctrl", {tcdm_req_o, stream_ready_o, busy_o, done_o}, '0);
        chk("reset_add", tcdm_add_o, '0);
        chk("reset_data_be", {tcdm_data_o[111:0], tcdm_be_o}, '0);
        @(posedge clk);
        #1;
        rst_i = 1'b0; start_i = 1'b0; stream_valid_i = 1'b0;
        @(posedge clk);
        #1;

        // 1: three contiguous beats, full grant
        gnt_mode = 1'b1;
        run_xfer(32'h1000, 3, 0, 32'h0, 1, 0, -1, 1'b0);
        chk("t1_ready_span", 128'(last_acc - first_acc), 128'(2));

        // 2: port 2 grant held low for three working cycles
        hold_mask = 4'b0100; hold_left = 3;
        run_xfer(32'h1000, 2, 0, 32'h0, 1, 0, -1, 1'b0);
        chk("t2_req_cycles_p0", 128'(req_cyc[0]), 128'(2));
        chk("t2_req_cycles_p1", 128'(req_cyc[1]), 128'(2));
        chk("t2_req_cycles_p2", 128'(req_cyc[2]), 128'(5));
        chk("t2_req_cycles_p3", 128'(req_cyc[3]), 128'(2));
        hold_left = 0;

        // 3: 2D with line length 2, stride 0x100
        run_xfer(32'h1000, 5, 2, 32'h100, 1, 0, -1, 1'b0);

        // 4: partial and empty strobes
        run_xfer(32'h1000, 3, 0, 32'h0, 2, 0, -1, 1'b0);
        chk("t4_req_cycles_p1", 128'(req_cyc[1]), 128'(1));
        chk("t4_req_cycles_p0", 128'(req_cyc[0]), 128'(2));

        // 5: zero-length transfer
        for (int p = 0; p < NB; p++) req_cyc[p] = 0;
        exp_trans = 0; acc_cnt = 0; d0 = done_seen;
        start_i = 1'b1; trans_size_i = '0; base_addr_i = 32'h1000;
        @(negedge clk);
        chk("t5_before", {busy_o, done_o}, '0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("t5_done_cycle", {busy_o, done_o, tcdm_req_o}, {1'b1, 1'b1, 4'b0000});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_after", {busy_o, done_o}, '0);
        chk("t5_no_req", 128'(req_cyc[0] + req_cyc[1] + req_cyc[2] + req_cyc[3]), 128'(0));
        chk("t5_done_seen", 128'(done_seen - d0), 128'(1));
        @(posedge clk);
        #1;

        // 6: reset and clear mid-transfer, then restart from base
        gnt_mode = 1'b0;
        run_xfer(32'h2000, 8, 0, 32'h0, 1, 1, 2, 1'b0);
        run_xfer(32'h2000, 4, 0, 32'h0, 1, 1, -1, 1'b0);
        run_xfer(32'h3000, 6, 3, 32'h40, 1, 0, 1, 1'b1);
        run_xfer(32'h3000, 6, 3, 32'h40, 1, 0, -1, 1'b0);

        // Randomized transfers
        for (int i = 0; i < 25; i++) begin
            gnt_mode = ($urandom_range(3, 0) == 0);
            run_xfer($urandom, $urandom_range(20, 1), $urandom_range(4, 0),
                     $urandom & 32'h0000_FFFC, 0, 2, -1, 1'b0);
        end

        finish_now();
    end
endmodule
